// File: rtl/sport_abuf_pkg.sv
// Shared types and constants for the SPORT0 autobuffer controller.
package sport_abuf_pkg;

    localparam int AW_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_TBASE = 3'd0;
    localparam logic [2:0] SEL_TLEN  = 3'd1;
    localparam logic [2:0] SEL_TMOD  = 3'd2;
    localparam logic [2:0] SEL_RBASE = 3'd3;
    localparam logic [2:0] SEL_RLEN  = 3'd4;
    localparam logic [2:0] SEL_RMOD  = 3'd5;

    localparam logic CH_TX = 1'b0;
    localparam logic CH_RX = 1'b1;

endpackage

// File: rtl/sport_abuf_dag.sv
// Per-channel circular address generator: addr = BASE + offset, combinational next offset/wrap.
// Offset advances only on step; a BASE or LEN write resets it and wins over a coincident step.
module sport_abuf_dag
    import sport_abuf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_base,
    input  logic          wr_len,
    input  logic          wr_mod,
    input  logic [AW-1:0] wdata,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          wrap
);

    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [AW-1:0] mod;
    logic [AW-1:0] offset;
    logic [AW-1:0] offset_nxt;
    logic [AW:0]   sum;

    // Low bits of (sum - len) equal the true difference whenever sum >= len.
    always_comb begin
        sum        = {1'b0, offset} + {1'b0, mod};
        offset_nxt = sum[AW-1:0];
        wrap       = 1'b0;
        if ((len != '0) && (sum >= {1'b0, len})) begin
            offset_nxt = sum[AW-1:0] - len;
            wrap       = 1'b1;
        end
    end

    assign addr = base + offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            len    <= '0;
            mod    <= '0;
            offset <= '0;
        end else begin
            if (wr_base) base <= wdata;
            if (wr_len)  len  <= wdata;
            if (wr_mod)  mod  <= wdata;
            if (wr_base || wr_len) begin
                offset <= '0;
            end else if (step) begin
                offset <= offset_nxt;
            end
        end
    end

endmodule

// File: rtl/sport_abuf_ctl.sv
// SPORT0 autobuffer controller: arbitrates TX/RX requests (RX first) onto one DM cycle; DM_req 1 cycle after eligible, ack 1 cycle after grant.
// Holds DM_req/DM_addr stable until DM_gnt; dropping ABUF_EN aborts without ack. SPORT_ABUF_STATS_EN adds TCNT/RCNT.
module sport_abuf_ctl
    import sport_abuf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          DSPCLK,
    input  logic          RST,
    input  logic          ABUF_EN,
    input  logic          TSreq,
    input  logic          RSreq,
    input  logic          CFG_we,
    input  logic [2:0]    CFG_sel,
    input  logic [15:0]   CFG_data,
    input  logic          DM_gnt,
    output logic          DM_req,
    output logic [AW-1:0] DM_addr,
    output logic          DM_wr,
    output logic          TSack,
    output logic          RSack,
    output logic          Twrap,
    output logic          Rwrap
`ifdef SPORT_ABUF_STATS_EN
    ,
    output logic [7:0]    TCNT,
    output logic [7:0]    RCNT
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic          ch;
    logic          t_served;
    logic          r_served;
    logic          t_elig;
    logic          r_elig;
    logic [AW-1:0] t_addr;
    logic [AW-1:0] r_addr;
    logic          t_wrap;
    logic          r_wrap;
    logic          t_step;
    logic          r_step;
    logic [AW-1:0] cfg_wdata;
    logic          cfg_data_unused;

    assign cfg_wdata       = CFG_data[AW-1:0];
    assign cfg_data_unused = ^CFG_data[15:AW];

    sport_abuf_dag #(.AW(AW)) u_tx_dag (
        .clk     (DSPCLK),
        .rst     (RST),
        .wr_base (CFG_we && (CFG_sel == SEL_TBASE)),
        .wr_len  (CFG_we && (CFG_sel == SEL_TLEN)),
        .wr_mod  (CFG_we && (CFG_sel == SEL_TMOD)),
        .wdata   (cfg_wdata),
        .step    (t_step),
        .addr    (t_addr),
        .wrap    (t_wrap)
    );

    sport_abuf_dag #(.AW(AW)) u_rx_dag (
        .clk     (DSPCLK),
        .rst     (RST),
        .wr_base (CFG_we && (CFG_sel == SEL_RBASE)),
        .wr_len  (CFG_we && (CFG_sel == SEL_RLEN)),
        .wr_mod  (CFG_we && (CFG_sel == SEL_RMOD)),
        .wdata   (cfg_wdata),
        .step    (r_step),
        .addr    (r_addr),
        .wrap    (r_wrap)
    );

    // Served flags block re-service while the SPORT is still dropping its request.
    assign t_elig = ABUF_EN && TSreq && !t_served;
    assign r_elig = ABUF_EN && RSreq && !r_served;

    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        DM_req    = 1'b0;
        TSack     = 1'b0;
        RSack     = 1'b0;
        Twrap     = 1'b0;
        Rwrap     = 1'b0;
        t_step    = 1'b0;
        r_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (t_elig || r_elig) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                DM_req = 1'b1;
                if (DM_gnt)        state_nxt = ST_ACK;
                else if (!ABUF_EN) state_nxt = ST_IDLE;
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
                if (ch == CH_RX) begin
                    RSack  = 1'b1;
                    Rwrap  = r_wrap;
                    r_step = 1'b1;
                end else begin
                    TSack  = 1'b1;
                    Twrap  = t_wrap;
                    t_step = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Channel, address and direction are captured once so CFG writes cannot move an issued request.
    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) begin
            ch      <= CH_TX;
            DM_addr <= '0;
            DM_wr   <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (r_elig) begin
                ch      <= CH_RX;
                DM_addr <= r_addr;
                DM_wr   <= 1'b1;
            end else if (t_elig) begin
                ch      <= CH_TX;
                DM_addr <= t_addr;
                DM_wr   <= 1'b0;
            end
        end
    end

    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) begin
            t_served <= 1'b0;
            r_served <= 1'b0;
        end else begin
            if (t_step)      t_served <= 1'b1;
            else if (!TSreq) t_served <= 1'b0;
            if (r_step)      r_served <= 1'b1;
            else if (!RSreq) r_served <= 1'b0;
        end
    end

`ifdef SPORT_ABUF_STATS_EN
    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) begin
            TCNT <= '0;
            RCNT <= '0;
        end else begin
            if (CFG_we && (CFG_sel == SEL_TBASE)) TCNT <= '0;
            else if (t_step && (TCNT != 8'hFF))   TCNT <= TCNT + 8'd1;
            if (CFG_we && (CFG_sel == SEL_RBASE)) RCNT <= '0;
            else if (r_step && (RCNT != 8'hFF))   RCNT <= RCNT + 8'd1;
        end
    end
`endif

endmodule

// File: doc/sport_abuf_ctl.md
Name: sport_abuf_ctl

Overview:
Autobuffer controller for SPORT0; the stage directly upstream of the SPORT's TSack/RSack/Twrap/Rwrap inputs.
- Consumes the SPORT's TSreq/RSreq autobuffer requests and arbitrates them onto a single stolen data-memory cycle.
- Generates circular-buffer addresses per channel.
- Returns one-cycle acknowledges, with wrap flags, to the SPORT.

Parameters:
AW, 14, data-memory address and buffer length/offset/modify width

Ports:
DSPCLK  in  1  system clock; all state on rising edge
RST  in  1  reset, asynchronous, active-high
ABUF_EN  in  1  autobuffer enable (SPORT autobuffer mode bit)
TSreq  in  1  TX autobuffer request, level, held until TSack
RSreq  in  1  RX autobuffer request, level, held until RSack
CFG_we  in  1  configuration write strobe
CFG_sel  in  3  register select: 0 TBASE, 1 TLEN, 2 TMOD, 3 RBASE, 4 RLEN, 5 RMOD; 6-7 ignored
CFG_data  in  16  write data; low AW bits used
DM_gnt  in  1  core grants the DM cycle requested this cycle
DM_req  out  1  DM cycle request
DM_addr  out  AW  DM address, valid while DM_req=1
DM_wr  out  1  1 = RX store to DM, 0 = TX fetch
TSack  out  1  one-cycle TX service pulse
RSack  out  1  one-cycle RX service pulse
Twrap  out  1  TX buffer wrapped; coincident with TSack
Rwrap  out  1  RX buffer wrapped; coincident with RSack

Behaviour:
Reset:
- Async assert forces state IDLE.
- All outputs 0; all BASE/LEN/MOD/offset registers 0; served flags 0.

Per-channel registers:
- Address = BASE + offset, modulo 2^AW.
- Any CFG write to BASE or LEN clears that channel's offset.
- A CFG write to the channel currently in REQ does not disturb the latched DM_addr; it applies from the next transfer.

Offset update at ack:
- n = offset + MOD, computed AW+1 bits wide.
- If LEN != 0 and n >= LEN: offset <= n - LEN, wrap flag = 1.
- Else: offset <= n[AW-1:0], wrap = 0.
- LEN == 0 means linear mode: the offset wraps modulo 2^AW and the wrap flag is never raised.

Served flags:
- A channel's flag sets at its ack.
- It clears when that channel's request is observed low.
- A request is eligible only when ABUF_EN=1, the request is high and its served flag is 0. This prevents double service while the SPORT drops its request.

FSM:
- IDLE
  - If any request is eligible: go to REQ, latch channel (RX has priority over TX), DM_addr and DM_wr.
- REQ
  - DM_req=1.
  - DM_gnt=1: go to ACK.
  - ABUF_EN=0: abort to IDLE with no ack and offset unchanged.
  - Otherwise hold, with the address stable.
- ACK
  - Pulse the channel's ack and wrap flag for exactly one cycle.
  - Update the offset and set the served flag.
  - Go to IDLE.

Latency:
- Request eligible in cycle n gives DM_req in n+1.
- Grant in cycle m gives the ack in m+1.
- Minimum 3 cycles from request to the next possible service.

Simultaneous events:
- TX and RX eligible together: RX is served first, then TX from the next IDLE.
- TSack and RSack are never high in the same cycle.

Optional Feature:
SPORT_ABUF_STATS_EN:
- When defined, adds outputs TCNT[7:0] and RCNT[7:0].
  - These are saturating counts of completed transfers per channel, incremented in ACK and held at 255.
  - Both are cleared by RST and by a CFG write of that channel's BASE.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package sport_abuf_pkg holds:
  - AW default
  - FSM state encoding (IDLE/REQ/ACK)
  - CFG_sel codes
  - channel index constants (CH_TX, CH_RX)
- Sub-module sport_abuf_dag, instantiated once per channel:
  - holds the BASE/LEN/MOD/offset registers
  - computes the next address and next offset/wrap
  - updates its offset only on a step strobe from the top FSM

Test Plan:
- TBASE=0x0100, TLEN=3, TMOD=1; hold TSreq, grant immediately → DM_addr 0x0100, 0x0101, 0x0102, 0x0100; Twrap=1 only with the third TSack; each TSack is exactly one cycle wide.
- TSreq and RSreq rise in the same cycle, RBASE=0x0200 → first DM_req has DM_addr=0x0200 and DM_wr=1, then RSack; the next DM_req has the TX address with DM_wr=0; the acks never overlap.
- DM_gnt held 0 for 5 cycles in REQ → DM_req and DM_addr are stable for all 5 cycles; the ack arrives exactly 1 cycle after DM_gnt rises.
- ABUF_EN dropped while in REQ → DM_req falls the next cycle, no ack, offset unchanged; re-enabling reissues the same address.
- RLEN=0, RMOD=0x3FFF, offset 1 → next address is RBASE+0, Rwrap=0 (linear modulo 2^14).
- RST asserted mid-REQ, asynchronously and not clock-aligned → DM_req and all acks go to 0 immediately; after release, offsets are 0 and the FSM is in IDLE.
